output_collector: RTL and testbench

OUTPUT_COLLECTOR -- requirements
Module: output_collector

---
 rtl/collector_pkg.sv | 16 +
 rtl/colbuf_fifo.sv | 57 +++++
 rtl/output_collector.sv | 90 +++++++++
 tb/tb_output_collector.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/collector_pkg.sv
`default_nettype none
// ============================================================================
// collector_pkg : shared constants for the output collector
// Revision      : 1.0
// ============================================================================
package collector_pkg;

  localparam logic WRV_INDEP = 1'b0;
  localparam logic WRV_SKEW  = 1'b1;

  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 16;

endpackage
`default_nettype wire

// File: rtl/colbuf_fifo.sv
`default_nettype none
// ============================================================================
// colbuf_fifo : single-clock per-column FIFO with show-ahead head output
// Revision    : 1.0
// ============================================================================
module colbuf_fifo #(
  parameter int bw    = 16,
  parameter int depth = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          rd,
  input  logic [bw-1:0] in,
  output logic [bw-1:0] out,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(depth);

  logic [bw-1:0] mem_q [depth];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   count_q;
  logic          do_wr;
  logic          do_rd;

  assign o_full  = (count_q == (AW+1)'(depth));
  assign o_empty = (count_q == '0);
  // A write to a full column is dropped even if the same edge pops it.
  assign do_wr   = wr & ~o_full;
  assign do_rd   = rd & ~o_empty;
  assign out     = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + AW'(1);
      if (do_rd) rptr_q <= rptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && do_wr) mem_q[wptr_q] <= in;
  end

endmodule
`default_nettype wire

// File: rtl/output_collector.sv
`default_nettype none
// ============================================================================
// output_collector : per-column FIFOs aligned into rows, optional skewed strobes
// Revision         : 1.0
// ============================================================================
module output_collector
  import collector_pkg::*;
#(
  parameter int col   = COL,
  parameter int bw    = BW,
  parameter int depth = DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [col*bw-1:0] in,
  input  logic [col-1:0]    wr,
  input  logic              wr_version,
  input  logic              rd,
  output logic [col*bw-1:0] out,
  output logic              o_valid,
  output logic              o_out_valid,
  output logic              o_full,
  output logic              o_empty
);

  logic [col-2:0]    skew_q;
  logic [col-2:0]    skew_d;
  logic [col-1:0]    we;
  logic [col-1:0]    full;
  logic [col-1:0]    empty;
  logic [col*bw-1:0] head;
  logic [col*bw-1:0] out_q;
  logic              out_valid_q;
  logic              skew_mode;
  logic              pop;

  assign skew_mode = (wr_version == WRV_SKEW);

  // In-flight skew bits keep firing after a switch back to independent mode.
  always_comb begin
    we     = '0;
    skew_d = '0;
    we[0]  = wr[0];
    for (int i = 1; i < col; i++) begin
      we[i] = (wr[i] & ~skew_mode) | skew_q[i-1];
    end
    skew_d[0] = wr[0] & skew_mode;
    for (int i = 1; i < col - 1; i++) begin
      skew_d[i] = skew_q[i-1];
    end
  end

  assign o_valid = &(~empty);
  assign o_full  = |full;
  assign o_empty = &empty;
  assign pop     = rd & o_valid;

  for (genvar i = 0; i < col; i++) begin : g_col
    colbuf_fifo #(
      .bw    (bw),
      .depth (depth)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr      (we[i]),
      .rd      (pop),
      .in      (in[bw*i +: bw]),
      .out     (head[bw*i +: bw]),
      .o_full  (full[i]),
      .o_empty (empty[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      skew_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      skew_q      <= skew_d;
      out_valid_q <= pop;
      if (pop) out_q <= head;
    end
  end

  assign out         = out_q;
  assign o_out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_output_collector.sv
`default_nettype none
// ============================================================================
// tb_output_collector : table vectors plus row scoreboard for output_collector
// Revision            : 1.0
// ============================================================================
module tb_output_collector;

  logic         clk;
  logic         reset;
  logic [127:0] in_d;
  logic [7:0]   wr;
  logic         wr_version;
  logic         rd;
  logic [127:0] out;
  logic         o_valid;
  logic         o_out_valid;
  logic         o_full;
  logic         o_empty;

  int n_chk;
  int n_fail;

  output_collector #(.col(8), .bw(16), .depth(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in_d),
    .wr          (wr),
    .wr_version  (wr_version),
    .rd          (rd),
    .out         (out),
    .o_valid     (o_valid),
    .o_out_valid (o_out_valid),
    .o_full      (o_full),
    .o_empty     (o_empty)
  );

  always #5 clk = ~clk;

  // Reference model: column queues, pending skew strobes, popped-row scoreboard
  bit   [15:0]  mq [8][$];
  bit           pend [8];
  logic [127:0] exp_q [$];
  logic [127:0] out_m;

  typedef struct {
    logic [7:0] w;
    logic       r;
    int         k;
    logic       ev;
    logic       eov;
    logic       ee;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] row_data(input int k);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[16*i +: 16] = 16'(i * 16 + k);
    return r;
  endfunction

  function automatic logic [127:0] skew_data(input int t);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[16*i +: 16] = 16'(32'hA000 + i * 256 + t);
    return r;
  endfunction

  function automatic logic [127:0] fill(input logic [15:0] v);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[16*i +: 16] = v;
    return r;
  endfunction

  task automatic cycle(input logic [7:0] w, input logic wv, input logic r, input logic [127:0] d);
    logic [7:0]   we;
    logic         popm;
    logic [127:0] row;
    int           sz [8];
    logic         vm, fm, em;
    wr = w; wr_version = wv; rd = r; in_d = d;
    for (int i = 0; i < 8; i++) sz[i] = mq[i].size();
    we[0] = w[0];
    for (int i = 1; i < 8; i++) we[i] = (w[i] & ~wv) | pend[i];
    for (int i = 7; i >= 2; i--) pend[i] = pend[i-1];
    pend[1] = w[0] & wv;
    popm = r;
    for (int i = 0; i < 8; i++) if (sz[i] == 0) popm = 1'b0;
    row = '0;
    if (popm) for (int i = 0; i < 8; i++) row[16*i +: 16] = mq[i].pop_front();
    for (int i = 0; i < 8; i++) if (we[i] && sz[i] < 16) mq[i].push_back(d[16*i +: 16]);
    if (popm) exp_q.push_back(row);
    @(posedge clk); #1;
    check("out_valid", 128'(o_out_valid), 128'(popm));
    if (popm) out_m = exp_q.pop_front();
    check("out_row", out, out_m);
    vm = 1'b1; fm = 1'b0; em = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (mq[i].size() == 0) vm = 1'b0; else em = 1'b0;
      if (mq[i].size() == 16) fm = 1'b1;
    end
    check("o_valid", 128'(o_valid), 128'(vm));
    check("o_full", 128'(o_full), 128'(fm));
    check("o_empty", 128'(o_empty), 128'(em));
  endtask

  task automatic do_reset(input logic [7:0] w);
    reset = 1'b0; wr = w; rd = 1'b0; in_d = fill(16'hBEEF);
    @(posedge clk); #1;
    reset = 1'b1; wr = '0;
    for (int i = 0; i < 8; i++) begin
      mq[i].delete();
      pend[i] = 1'b0;
    end
    exp_q.delete();
    out_m = '0;
    check("rst_empty", 128'(o_empty), 128'd1);
    check("rst_out", out, 128'd0);
    check("rst_out_valid", 128'(o_out_valid), 128'd0);
    check("rst_valid", 128'(o_valid), 128'd0);
    check("rst_full", 128'(o_full), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int           lat;
    logic [127:0] er;
    n_chk = 0; n_fail = 0;
    clk = 0; reset = 0; wr = '0; wr_version = 1'b0; rd = 1'b0; in_d = '0; out_m = '0;

    //             w      r     k   ev    eov   ee
    tbl[0]  = '{8'hFF, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{8'hFF, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{8'hFF, 1'b0, 2, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{8'h00, 1'b1, 0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{8'h00, 1'b1, 0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{8'h7F, 1'b0, 3, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{8'h00, 1'b1, 0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{8'h80, 1'b0, 4, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    do_reset(8'h00);

    // Independent fill / drain, then partial rows
    for (int v = 0; v < 11; v++) begin
      cycle(tbl[v].w, 1'b0, tbl[v].r, row_data(tbl[v].k));
      check($sformatf("tbl%0d_valid", v), 128'(o_valid), 128'(tbl[v].ev));
      check($sformatf("tbl%0d_out_valid", v), 128'(o_out_valid), 128'(tbl[v].eov));
      check($sformatf("tbl%0d_empty", v), 128'(o_empty), 128'(tbl[v].ee));
    end

    // Skewed write: one wr[0] pulse fans out over 7 further cycles
    do_reset(8'h00);
    cycle(8'h01, 1'b1, 1'b0, skew_data(0));
    lat = 0;
    while (!o_valid && lat < 20) begin
      lat++;
      cycle(8'hFE, 1'b1, 1'b0, skew_data(lat));
    end
    check("skew_latency", 128'(lat), 128'd7);
    cycle(8'h00, 1'b1, 1'b1, '0);
    for (int i = 0; i < 8; i++) er[16*i +: 16] = 16'(32'hA000 + i * 257);
    check("skew_row", out, er);

    // Mode switch mid-stream: in-flight skew bits still land
    do_reset(8'h00);
    cycle(8'h01, 1'b1, 1'b0, fill(16'h1111));
    for (int t = 0; t < 7; t++) cycle(8'h00, 1'b0, 1'b0, fill(16'(32'h2220 + t)));
    check("switch_valid", 128'(o_valid), 128'd1);
    cycle(8'h00, 1'b0, 1'b1, '0);

    // Full / drop on column 3, then simultaneous pop+write on full columns
    do_reset(8'h00);
    for (int n = 0; n < 17; n++) begin
      cycle(8'h08, 1'b0, 1'b0, fill(16'(32'h3000 + n)));
      if (n == 14) check("col3_not_full_15", 128'(o_full), 128'd0);
      if (n == 15) check("col3_full_16", 128'(o_full), 128'd1);
    end
    for (int n = 0; n < 16; n++) cycle(8'hF7, 1'b0, 1'b0, fill(16'(32'h5000 + n)));
    cycle(8'hFF, 1'b0, 1'b1, fill(16'hDEAD));
    check("simul_full_cleared", 128'(o_full), 128'd0);
    for (int n = 0; n < 15; n++) cycle(8'h00, 1'b0, 1'b1, '0);
    check("drain_15_empty", 128'(o_empty), 128'd1);
    cycle(8'h00, 1'b0, 1'b1, '0);

    // Reset mid-stream with stored rows and a skew pulse in flight
    do_reset(8'h00);
    for (int n = 0; n < 5; n++) cycle(8'hFF, 1'b0, 1'b0, row_data(n));
    cycle(8'h01, 1'b1, 1'b0, fill(16'h7777));
    cycle(8'h00, 1'b1, 1'b0, fill(16'h7778));
    do_reset(8'hFF);
    for (int t = 0; t < 8; t++) cycle(8'h00, 1'b1, 1'b0, fill(16'h9999));
    check("post_reset_skew_clear", 128'(o_empty), 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
